// File: rtl/rand_init_sequencer.sv
// Turns 64-bit LFSR words into a scaled, addressed sample stream for memory initialisation.
// Each fetched word is split into OUT_W-bit lanes, LSB lane first, and every lane becomes one write.
module rand_init_sequencer #(
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned NUM_SAMPLES = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OUT_W-1:0]  min_val,
  input  logic [OUT_W-1:0]  range,
  input  logic [63:0]       lfsr_data,
  output logic              lfsr_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LANES  = 64 / OUT_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [63:0]       word_q, word_d;
  logic [OUT_W-1:0]  min_q, min_d;
  logic [OUT_W-1:0]  range_q, range_d;

  logic [OUT_W-1:0]   slice;
  logic [2*OUT_W-1:0] prod;
  logic [OUT_W-1:0]   scaled;
  logic               last_sample;
  logic               last_lane;
  logic               unused_prod_lo;

  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) slice = word_q[i*OUT_W +: OUT_W];
    end
  end

  // Upper half of slice*range maps the lane uniformly onto [0, range).
  assign prod           = {{OUT_W{1'b0}}, slice} * {{OUT_W{1'b0}}, range_q};
  assign scaled         = min_q + prod[2*OUT_W-1:OUT_W];
  assign unused_prod_lo = ^prod[OUT_W-1:0];

  assign last_sample = (({1'b0, cnt_q} + (ADDR_W+1)'(1)) == (ADDR_W+1)'(NUM_SAMPLES));
  assign last_lane   = (lane_q == LANE_W'(LANES - 1));

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    min_d       = min_q;
    range_d     = range_q;
    lfsr_enable = 1'b0;
    out_valid   = 1'b0;
    out_addr    = '0;
    out_data    = '0;
    busy        = (state_q != StIdle);
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          min_d   = min_val;
          range_d = range;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Capture the pre-advance word while asking the LFSR to step.
        lfsr_enable = 1'b1;
        word_d      = lfsr_data;
        lane_d      = '0;
        state_d     = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        out_addr  = cnt_q;
        out_data  = scaled;
        if (out_ready) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_sample) begin
            state_d = StDone;
          end else if (last_lane) begin
            state_d = StFetch;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      min_q   <= '0;
      range_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      min_q   <= min_d;
      range_q <= range_d;
    end
  end

endmodule

// File: tb/tb_rand_init_sequencer.sv
// Directed bench for rand_init_sequencer with 16-bit lanes and a 6-sample run (one partial word).
module tb_rand_init_sequencer;

  localparam int unsigned OUT_W       = 16;
  localparam int unsigned NUM_SAMPLES = 6;
  localparam int unsigned ADDR_W      = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [OUT_W-1:0]  min_val = '0;
  logic [OUT_W-1:0]  rng = '0;
  logic [63:0]       lfsr_data = '0;
  logic              lfsr_enable;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_basic [6];
  logic [15:0] exp_zero  [6];
  logic [15:0] exp_wrap  [6];
  logic [15:0] exp_mix   [6];

  rand_init_sequencer #(
    .OUT_W      (OUT_W),
    .NUM_SAMPLES(NUM_SAMPLES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .min_val    (min_val),
    .range      (rng),
    .lfsr_data  (lfsr_data),
    .lfsr_enable(lfsr_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full run; optionally stalls the sink at stall_at or re-pulses start at poke_at.
  task automatic run(input string name, input logic [15:0] mn, input logic [15:0] rg,
                     input logic [63:0] word, input logic [15:0] exp [6],
                     input int stall_at, input int poke_at);
    int          edges;
    int          first_v;
    int          n_s;
    int          n_en;
    int          n_done;
    logic        fin;
    logic [15:0] hd;
    logic [7:0]  ha;
    logic [15:0] got_d [6];
    logic [7:0]  got_a [6];
    for (int i = 0; i < 6; i++) begin
      got_d[i] = 'x;
      got_a[i] = 'x;
    end
    lfsr_data = word;
    min_val   = mn;
    rng       = rg;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start   = 1'b0;
    edges   = 1;
    first_v = -1;
    n_s     = 0;
    n_en    = 0;
    n_done  = 0;
    fin     = 1'b0;
    while (!fin && edges < 60) begin
      if (lfsr_enable) n_en++;
      if (out_valid) begin
        if (first_v < 0) first_v = edges;
        if (int'(out_addr) == stall_at) begin
          out_ready = 1'b0;
          hd = out_data;
          ha = out_addr;
          for (int k = 0; k < 5; k++) begin
            step();
            edges++;
            chk({name, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_stall_data"}, 64'(out_data), 64'(hd));
            chk({name, "_stall_addr"}, 64'(out_addr), 64'(ha));
            chk({name, "_stall_enable"}, 64'(lfsr_enable), 64'd0);
          end
          out_ready = 1'b1;
          stall_at  = -1;
        end
        if (int'(out_addr) == poke_at) begin
          start   = 1'b1;
          min_val = ~mn;
          rng     = 16'h0001;
          poke_at = -1;
        end
        if (n_s < 6) begin
          got_d[n_s] = out_data;
          got_a[n_s] = out_addr;
        end
        n_s++;
      end
      if (done) begin
        n_done++;
        fin   = 1'b1;
        start = 1'b1;
      end
      step();
      edges++;
      start = 1'b0;
    end
    chk({name, "_finished"}, 64'(fin), 64'd1);
    chk({name, "_start_in_done_busy"}, 64'(busy), 64'd0);
    chk({name, "_start_in_done_enable"}, 64'(lfsr_enable), 64'd0);
    step();
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_samples"}, 64'(n_s), 64'd6);
    chk({name, "_enable_pulses"}, 64'(n_en), 64'd2);
    chk({name, "_done_pulses"}, 64'(n_done), 64'd1);
    chk({name, "_first_valid_edge"}, 64'(first_v), 64'd2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_addr%0d", name, i), 64'(got_a[i]), 64'(i));
      chk($sformatf("%s_data%0d", name, i), 64'(got_d[i]), 64'(exp[i]));
    end
    min_val = mn;
    rng     = rg;
  endtask

  initial begin : main
    int found;
    int dones;
    // slice*0xFFFF >> 16 == slice-1 for nonzero slices; second word repeats lanes 0..1.
    exp_basic = '{16'h5677, 16'h1233, 16'hBEEE, 16'hDEAC, 16'h5677, 16'h1233};
    exp_zero  = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    // 0xFFF0 + (0xFFFF*0x20 >> 16 = 0x1F) wraps to 0x000F.
    exp_wrap  = '{16'h000F, 16'h000F, 16'h000F, 16'h000F, 16'h000F, 16'h000F};
    // Lanes 0x0000, 0xFFFF, 0x8000, 0x0001 with min 0x0100 and range 0x8000.
    exp_mix   = '{16'h0100, 16'h80FF, 16'h4100, 16'h0100, 16'h0100, 16'h80FF};

    rst_n = 1'b0;
    step();
    step();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_enable", 64'(lfsr_enable), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_addr", 64'(out_addr), 64'd0);
    rst_n = 1'b1;
    step();

    run("basic", 16'h0000, 16'hFFFF, 64'hDEADBEEF12345678, exp_basic, -1, -1);
    run("range0", 16'h1234, 16'h0000, 64'hA5A5C3C3F00F1234, exp_zero, -1, -1);
    run("wrap", 16'hFFF0, 16'h0020, 64'hFFFFFFFFFFFFFFFF, exp_wrap, -1, -1);
    run("mix", 16'h0100, 16'h8000, 64'h00018000FFFF0000, exp_mix, -1, -1);
    run("stall", 16'h0000, 16'hFFFF, 64'hDEADBEEF12345678, exp_basic, 1, -1);
    run("busy_start", 16'h0000, 16'hFFFF, 64'hDEADBEEF12345678, exp_basic, -1, 1);

    // Abort a run once sample 2 is on the bus.
    lfsr_data = 64'hDEADBEEF12345678;
    min_val   = 16'h0000;
    rng       = 16'hFFFF;
    start     = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (out_valid && out_addr == 8'd2) found = 1;
      else step();
    end
    chk("abort_reached_sample2", 64'(found), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_enable", 64'(lfsr_enable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_addr", 64'(out_addr), 64'd0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done || busy) dones++;
    end
    chk("abort_stays_idle", 64'(dones), 64'd0);

    run("after_abort", 16'h0000, 16'hFFFF, 64'hDEADBEEF12345678, exp_basic, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
